// File: rtl/aer_in_hsk.sv
// AER input handshake receiver.
// Synchronizes the asynchronous 4-phase request, captures the bundled event word,
// writes it into a downstream FIFO with one strobe per event, and returns the
// acknowledge only once the word has actually been written.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   REL   | after reset: wait for a settled, low request before accepting
//   IDLE  | waiting for a synchronized request with enable high
//   PUSH  | word captured in fifo_a; write as soon as the FIFO has room
//   HOLD  | written and acknowledged; wait for the request to drop
module aer_in_hsk #(
    parameter int dsize = 8,
    parameter int nsync = 2
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             aer_req,
    input  logic [dsize-1:0] aer_data,
    output logic             aer_ack,
    input  logic             enable,
    input  logic             fifo_full,
    output logic [dsize-1:0] fifo_a,
    output logic             fifo_wr,
    output logic             stall,
    output logic [15:0]      evt_cnt
);

    typedef enum logic [1:0] {REL, IDLE, PUSH, HOLD} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [nsync-1:0] sync_q;
    logic [nsync-1:0] vld_q;
    logic             req_s;
    logic             ack_d;
    logic             wr_d;
    logic             stall_d;
    logic             load_a;
    logic             inc_cnt;

    assign req_s = sync_q[nsync-1];

    // Request synchronizer. vld_q fills with ones alongside it so REL can tell
    // a genuinely low request apart from the zeros the chain holds after reset.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            sync_q <= '0;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[nsync-2:0], aer_req};
            vld_q  <= {vld_q[nsync-2:0], 1'b1};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= REL;
            aer_ack <= 1'b0;
            fifo_wr <= 1'b0;
            stall   <= 1'b0;
            fifo_a  <= '0;
            evt_cnt <= 16'h0000;
        end else begin
            state_q <= state_d;
            aer_ack <= ack_d;
            fifo_wr <= wr_d;
            stall   <= stall_d;
            if (load_a) begin
                fifo_a <= aer_data;
            end
            if (inc_cnt) begin
                evt_cnt <= evt_cnt + 16'h0001;
            end
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        ack_d   = aer_ack;
        wr_d    = 1'b0;
        stall_d = stall;
        load_a  = 1'b0;
        inc_cnt = 1'b0;
        unique case (state_q)
            REL: begin
                ack_d   = 1'b0;
                stall_d = 1'b0;
                if (vld_q[nsync-1] && !req_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                ack_d   = 1'b0;
                stall_d = 1'b0;
                if (req_s && enable) begin
                    load_a  = 1'b1;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                // enable is deliberately ignored here: a captured event always completes.
                if (fifo_full) begin
                    ack_d   = 1'b0;
                    stall_d = 1'b1;
                end else begin
                    wr_d    = 1'b1;
                    ack_d   = 1'b1;
                    stall_d = 1'b0;
                    inc_cnt = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                stall_d = 1'b0;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                state_d = REL;
            end
        endcase
    end

endmodule

// File: tb/tb_aer_in_hsk.sv
// Directed testbench for aer_in_hsk: latency, backpressure, FIFO burst,
// enable gating, reset in mid-handshake and event counter wrap.
module tb_aer_in_hsk;

    logic        clk;
    logic        _rst;
    logic        aer_req;
    logic [7:0]  aer_data;
    logic        aer_ack;
    logic        enable;
    logic        fifo_full;
    logic [7:0]  fifo_a;
    logic        fifo_wr;
    logic        stall;
    logic [15:0] evt_cnt;

    int          n_chk;
    int          n_pass;
    int          wr_cnt;
    logic [7:0]  last_wr;
    logic [7:0]  wr_log[$];
    logic        full_force;
    logic        model_en;
    int          fifo_base;
    int          fifo_pops;
    int          wr0;
    logic [15:0] exp_cnt;

    aer_in_hsk #(.dsize(8), .nsync(2)) dut (
        .clk       (clk),
        ._rst      (_rst),
        .aer_req   (aer_req),
        .aer_data  (aer_data),
        .aer_ack   (aer_ack),
        .enable    (enable),
        .fifo_full (fifo_full),
        .fifo_a    (fifo_a),
        .fifo_wr   (fifo_wr),
        .stall     (stall),
        .evt_cnt   (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-entry downstream FIFO model: level = writes since base minus reads.
    assign fifo_full = full_force | (model_en & ((wr_cnt - fifo_base - fifo_pops) >= 4));

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            wr_cnt  = wr_cnt + 1;
            last_wr = fifo_a;
            wr_log.push_back(fifo_a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n;
        n = 0;
        while (aer_ack !== lvl && n < 60) begin
            tick(1);
            n = n + 1;
        end
        chk(tag, 32'(aer_ack), 32'(lvl));
    endtask

    task automatic send_evt(input logic [7:0] d, input string tag);
        aer_data = d;
        aer_req  = 1'b1;
        wait_ack(1'b1, {tag, "_ack_hi"});
        tick(1);
        aer_req = 1'b0;
        wait_ack(1'b0, {tag, "_ack_lo"});
        tick(2);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        wr_cnt     = 0;
        last_wr    = 8'h00;
        full_force = 1'b0;
        model_en   = 1'b0;
        fifo_base  = 0;
        fifo_pops  = 0;
        exp_cnt    = 16'h0000;
        _rst       = 1'b0;
        aer_req    = 1'b0;
        aer_data   = 8'h00;
        enable     = 1'b1;

        // Reset values
        tick(3);
        chk("rst_ack",   32'(aer_ack), 32'd0);
        chk("rst_wr",    32'(fifo_wr), 32'd0);
        chk("rst_stall", 32'(stall),   32'd0);
        chk("rst_fifo_a",32'(fifo_a),  32'd0);
        chk("rst_cnt",   32'(evt_cnt), 32'd0);
        _rst = 1'b1;
        tick(5);

        // Basic handshake and latency
        aer_data = 8'hA5;
        aer_req  = 1'b1;
        tick(3);
        chk("lat_e3_wr",     32'(fifo_wr), 32'd0);
        chk("lat_e3_ack",    32'(aer_ack), 32'd0);
        chk("lat_e3_fifo_a", 32'(fifo_a),  32'hA5);
        tick(1);
        chk("lat_e4_wr",  32'(fifo_wr), 32'd1);
        chk("lat_e4_ack", 32'(aer_ack), 32'd1);
        tick(1);
        chk("lat_e5_wr",  32'(fifo_wr), 32'd0);
        chk("lat_e5_ack", 32'(aer_ack), 32'd1);
        aer_req = 1'b0;
        tick(1);
        chk("rel_e1_ack", 32'(aer_ack), 32'd1);
        tick(2);
        chk("rel_e3_ack", 32'(aer_ack), 32'd0);
        exp_cnt = exp_cnt + 16'd1;
        chk("basic_cnt",  32'(evt_cnt), 32'(exp_cnt));
        chk("basic_nwr",  32'(wr_cnt),  32'd1);
        chk("basic_data", 32'(last_wr), 32'hA5);
        tick(3);

        // Backpressure
        full_force = 1'b1;
        wr0        = wr_cnt;
        aer_data   = 8'h3C;
        aer_req    = 1'b1;
        tick(6);
        tick(20);
        chk("bp_stall", 32'(stall),   32'd1);
        chk("bp_ack",   32'(aer_ack), 32'd0);
        chk("bp_nowr",  32'(wr_cnt),  32'(wr0));
        full_force = 1'b0;
        wait_ack(1'b1, "bp_ack_hi");
        chk("bp_wr1",   32'(wr_cnt),  32'(wr0 + 1));
        chk("bp_data",  32'(last_wr), 32'h3C);
        chk("bp_unstall", 32'(stall), 32'd0);
        aer_req = 1'b0;
        wait_ack(1'b0, "bp_ack_lo");
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_cnt", 32'(evt_cnt), 32'(exp_cnt));
        tick(2);

        // Burst into a 4-entry FIFO without reads
        fifo_base = wr_cnt;
        fifo_pops = 0;
        model_en  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_evt(8'(i), "burst");
            exp_cnt = exp_cnt + 16'd1;
        end
        for (int i = 0; i < 4; i++) begin
            chk("burst_data", 32'(wr_log[fifo_base + i]), 32'(i + 1));
        end
        chk("burst_full", 32'(fifo_full), 32'd1);
        aer_data = 8'h05;
        aer_req  = 1'b1;
        tick(30);
        chk("burst5_stall", 32'(stall),   32'd1);
        chk("burst5_ack",   32'(aer_ack), 32'd0);
        chk("burst5_nowr",  32'(wr_cnt),  32'(fifo_base + 4));
        fifo_pops = 1;
        wait_ack(1'b1, "burst5_ack_hi");
        chk("burst5_wr",   32'(wr_cnt),  32'(fifo_base + 5));
        chk("burst5_data", 32'(last_wr), 32'h05);
        aer_req = 1'b0;
        wait_ack(1'b0, "burst5_ack_lo");
        exp_cnt = exp_cnt + 16'd1;
        chk("burst_cnt", 32'(evt_cnt), 32'(exp_cnt));
        model_en = 1'b0;
        tick(2);

        // Enable gating
        wr0      = wr_cnt;
        enable   = 1'b0;
        aer_data = 8'h5A;
        aer_req  = 1'b1;
        tick(30);
        chk("en_ack",  32'(aer_ack), 32'd0);
        chk("en_nowr", 32'(wr_cnt),  32'(wr0));
        enable = 1'b1;
        wait_ack(1'b1, "en_ack_hi");
        aer_req = 1'b0;
        wait_ack(1'b0, "en_ack_lo");
        exp_cnt = exp_cnt + 16'd1;
        chk("en_wr",   32'(wr_cnt),  32'(wr0 + 1));
        chk("en_data", 32'(last_wr), 32'h5A);
        chk("en_cnt",  32'(evt_cnt), 32'(exp_cnt));
        tick(2);

        // Asynchronous reset while in HOLD with the request still high
        aer_data = 8'hC3;
        aer_req  = 1'b1;
        wait_ack(1'b1, "hrst_ack_hi");
        tick(2);
        _rst = 1'b0;
        #1;
        chk("hrst_ack",    32'(aer_ack), 32'd0);
        chk("hrst_cnt",    32'(evt_cnt), 32'd0);
        chk("hrst_fifo_a", 32'(fifo_a),  32'd0);
        wr0 = wr_cnt;
        tick(1);
        _rst = 1'b1;
        tick(20);
        chk("hrst_nowr",   32'(wr_cnt),  32'(wr0));
        chk("hrst_ack_lo", 32'(aer_ack), 32'd0);
        aer_req = 1'b0;
        tick(6);
        send_evt(8'h77, "hrst_new");
        exp_cnt = 16'd1;
        chk("hrst_wr1",  32'(wr_cnt),  32'(wr0 + 1));
        chk("hrst_data", 32'(last_wr), 32'h77);
        chk("hrst_cnt1", 32'(evt_cnt), 32'(exp_cnt));

        // Counter wrap: preload the counter to 0xFFFF
        force dut.evt_cnt = 16'hFFFF;
        #1;
        release dut.evt_cnt;
        tick(1);
        chk("wrap_pre", 32'(evt_cnt), 32'hFFFF);
        send_evt(8'h11, "wrap0");
        chk("wrap_zero", 32'(evt_cnt), 32'h0000);
        send_evt(8'h22, "wrap1");
        chk("wrap_one",  32'(evt_cnt), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
